// File: rtl/cosim_pkg.sv
// Shared types for the cosim commit scheduler: the buffered event record and FSM state.
package cosim_pkg;

  localparam logic EVT_COMMIT = 1'b0;
  localparam logic EVT_TRAP   = 1'b1;

  typedef struct packed {
    logic        kind;
    logic [63:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] cause;
  } cosim_evt_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    FAIL  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/cosim_commit_sched_if.sv
// Retirement bus from the hart plus the checker-side handshake of the commit scheduler.
interface cosim_commit_sched_if #(
  parameter int COMMITS = 2
);
  logic [COMMITS-1:0]    commit_valid;
  logic [64*COMMITS-1:0] commit_pc;
  logic [32*COMMITS-1:0] commit_insn;
  logic [COMMITS-1:0]    commit_wen;
  logic [5*COMMITS-1:0]  commit_waddr;
  logic [64*COMMITS-1:0] commit_wdata;
  logic                  trap_valid;
  logic [63:0]           trap_cause;
  logic                  finish_req;

  // Checker handshake: an event transfers on a cycle with chk_valid && chk_ready; while
  // chk_valid && !chk_ready every chk_* field holds. chk_fail is meaningful only on a transfer.
  logic                  chk_valid;
  logic                  chk_ready;
  logic                  chk_kind;
  logic [31:0]           chk_hartid;
  logic [63:0]           chk_pc;
  logic [31:0]           chk_insn;
  logic                  chk_wen;
  logic [4:0]            chk_waddr;
  logic [63:0]           chk_wdata;
  logic [63:0]           chk_cause;
  logic                  chk_fail;

  modport master (
    output commit_valid, commit_pc, commit_insn, commit_wen, commit_waddr, commit_wdata,
    output trap_valid, trap_cause, finish_req, chk_ready, chk_fail,
    input  chk_valid, chk_kind, chk_hartid, chk_pc, chk_insn, chk_wen, chk_waddr,
    input  chk_wdata, chk_cause
  );

  modport slave (
    input  commit_valid, commit_pc, commit_insn, commit_wen, commit_waddr, commit_wdata,
    input  trap_valid, trap_cause, finish_req, chk_ready, chk_fail,
    output chk_valid, chk_kind, chk_hartid, chk_pc, chk_insn, chk_wen, chk_waddr,
    output chk_wdata, chk_cause
  );
endinterface

// File: rtl/cosim_evt_fifo.sv
// Circular event buffer: up to NW entries written per cycle at consecutive slots, one read.
module cosim_evt_fifo
  import cosim_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int NW    = 3,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  cosim_evt_t [NW-1:0]  wr_data,
  input  logic [PW-1:0]        push_n,
  input  logic                 pop,
  output cosim_evt_t           head,
  output logic [PW-1:0]        count
);

  cosim_evt_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] wr_addr [NW];

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      wr_addr[i] = wr_ptr[AW-1:0] + AW'(i);
    end
  end

  // Pointers carry one extra bit so full and empty stay distinguishable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_n;
      rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, pop};
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NW; i++) begin
      if (PW'(i) < push_n) mem[wr_addr[i]] <= wr_data[i];
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cosim_commit_sched.sv
// Serialises multi-lane retirement plus traps into a one-per-cycle stream for the cosim
// checker and tracks run/drain/done/fail status.
module cosim_commit_sched
  import cosim_pkg::*;
#(
  parameter  int          COMMITS = 2,
  parameter  int          DEPTH   = 16,
  parameter  logic [31:0] HARTID  = 32'd0,
  localparam int          NW      = COMMITS + 1,
  localparam int          PW      = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  cosim_commit_sched_if.slave  bus,
  output logic [PW-1:0]        occupancy,
  output logic                 overflow,
  output logic                 done,
  output logic                 fail,
  output sched_state_e         state
);

  cosim_evt_t [NW-1:0] grp;
  logic [PW-1:0]       grp_n;
  logic [PW-1:0]       push_n;
  logic [PW:0]         free;
  logic                fits;
  logic                active;
  logic                pop;
  cosim_evt_t          head;
  int                  pos;

  // Compact valid lanes oldest first, then append the trap behind them.
  always_comb begin
    grp = '0;
    pos = 0;
    for (int i = 0; i < COMMITS; i++) begin
      if (bus.commit_valid[i]) begin
        for (int j = 0; j < NW; j++) begin
          if (j == pos) begin
            grp[j] = '{kind:  EVT_COMMIT,
                       pc:    bus.commit_pc[64*i +: 64],
                       insn:  bus.commit_insn[32*i +: 32],
                       wen:   bus.commit_wen[i],
                       waddr: bus.commit_waddr[5*i +: 5],
                       wdata: bus.commit_wdata[64*i +: 64],
                       cause: 64'd0};
          end
        end
        pos = pos + 1;
      end
    end
    if (bus.trap_valid) begin
      for (int j = 0; j < NW; j++) begin
        if (j == pos) begin
          grp[j] = '{kind: EVT_TRAP, pc: 64'd0, insn: 32'd0, wen: 1'b0, waddr: 5'd0,
                     wdata: 64'd0, cause: bus.trap_cause};
        end
      end
      pos = pos + 1;
    end
    grp_n = PW'(pos);
  end

  assign active        = (state == RUN) || (state == DRAIN);
  assign bus.chk_valid = active && (occupancy != '0);
  assign pop           = bus.chk_valid && bus.chk_ready;

  // A group that cannot fit whole is dropped whole; the hart is never back-pressured.
  assign free   = (PW+1)'(DEPTH) - {1'b0, occupancy} + {{PW{1'b0}}, pop};
  assign fits   = {1'b0, grp_n} <= free;
  assign push_n = (active && fits) ? grp_n : '0;

  cosim_evt_fifo #(.DEPTH(DEPTH), .NW(NW)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_data (grp),
    .push_n  (push_n),
    .pop     (pop),
    .head    (head),
    .count   (occupancy)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      overflow <= 1'b0;
    end else begin
      if (active && !fits) overflow <= 1'b1;
      case (state)
        RUN: begin
          if (pop && bus.chk_fail) state <= FAIL;
          else if (bus.finish_req) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && bus.chk_fail) state <= FAIL;
          else if (occupancy == '0 || (occupancy == PW'(1) && pop)) state <= DONE;
        end
        default: state <= state;
      endcase
    end
  end

  assign done = (state == DONE);
  assign fail = (state == FAIL);

  assign bus.chk_kind   = head.kind;
  assign bus.chk_hartid = HARTID;
  assign bus.chk_pc     = head.pc;
  assign bus.chk_insn   = head.insn;
  assign bus.chk_wen    = head.wen;
  assign bus.chk_waddr  = head.waddr;
  assign bus.chk_wdata  = head.wdata;
  assign bus.chk_cause  = head.cause;

endmodule

// File: tb/tb_cosim_commit_sched.sv
// Directed bench for cosim_commit_sched: ordering, compaction, overflow, drain, fail, reset.
module tb_cosim_commit_sched;
  import cosim_pkg::*;

  localparam int COMMITS = 2;
  localparam int DEPTH   = 16;
  localparam int PW      = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic [PW-1:0] occupancy;
  logic          overflow;
  logic          done;
  logic          fail;
  sched_state_e  state;

  int checks   = 0;
  int failures = 0;
  logic [64:0] exp_q[$];
  logic [64:0] exp_v;
  logic [64:0] got_v;

  cosim_commit_sched_if #(.COMMITS(COMMITS)) bus ();

  cosim_commit_sched #(.COMMITS(COMMITS), .DEPTH(DEPTH), .HARTID(32'd0)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .occupancy (occupancy),
    .overflow  (overflow),
    .done      (done),
    .fail      (fail),
    .state     (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs();
    bus.commit_valid = '0;
    bus.commit_pc    = '0;
    bus.commit_insn  = '0;
    bus.commit_wen   = '0;
    bus.commit_waddr = '0;
    bus.commit_wdata = '0;
    bus.trap_valid   = 1'b0;
    bus.trap_cause   = '0;
    bus.finish_req   = 1'b0;
    bus.chk_fail     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    bus.chk_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Drives one retirement cycle: lane i has pc = base + 4*i, waddr = 5+i.
  task automatic push_group(input logic [COMMITS-1:0] v, input logic t,
                            input logic [63:0] base, input logic [63:0] cause);
    bus.commit_valid = v;
    bus.commit_wen   = v;
    for (int i = 0; i < COMMITS; i++) begin
      bus.commit_pc[64*i +: 64]    = base + 64'(4*i);
      bus.commit_insn[32*i +: 32]  = 32'h13 + 32'(i);
      bus.commit_waddr[5*i +: 5]   = 5'(5 + i);
      bus.commit_wdata[64*i +: 64] = base ^ 64'hA5A5;
    end
    bus.trap_valid = t;
    bus.trap_cause = cause;
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (bus.chk_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.chk_valid); end
    checks++; if ({overflow, done, fail} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {overflow, done, fail}); end
    checks++; if (state !== RUN) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, RUN); end
  endtask

  task automatic test_two_lanes();
    bus.chk_ready = 1'b1;
    push_group(2'b11, 1'b0, 64'h8000_0000, 64'd0);
    checks++; if (occupancy !== 5'd2) begin failures++; $display("FAIL t1_occ2 got=%0d exp=2", occupancy); end
    checks++; if (bus.chk_valid !== 1'b1) begin failures++; $display("FAIL t1_valid got=%b exp=1", bus.chk_valid); end
    checks++; if (bus.chk_pc !== 64'h8000_0000) begin failures++; $display("FAIL t1_pc0 got=%h exp=80000000", bus.chk_pc); end
    checks++; if ({bus.chk_kind, bus.chk_waddr, bus.chk_insn} !== {1'b0, 5'd5, 32'h13}) begin failures++; $display("FAIL t1_fields0 got=%b/%0d/%h exp=0/5/13", bus.chk_kind, bus.chk_waddr, bus.chk_insn); end
    checks++; if (bus.chk_hartid !== 32'd0) begin failures++; $display("FAIL t1_hartid got=%0d exp=0", bus.chk_hartid); end
    @(negedge clock);
    checks++; if (occupancy !== 5'd1) begin failures++; $display("FAIL t1_occ1 got=%0d exp=1", occupancy); end
    checks++; if (bus.chk_pc !== 64'h8000_0004 || bus.chk_waddr !== 5'd6) begin failures++; $display("FAIL t1_pc1 got=%h/%0d exp=80000004/6", bus.chk_pc, bus.chk_waddr); end
    @(negedge clock);
    checks++; if (occupancy !== 5'd0 || bus.chk_valid !== 1'b0) begin failures++; $display("FAIL t1_empty got=%0d/%b exp=0/0", occupancy, bus.chk_valid); end
    checks++; if ({done, fail} !== 2'b00) begin failures++; $display("FAIL t1_status got=%b exp=00", {done, fail}); end
  endtask

  task automatic test_compact_trap();
    bus.chk_ready = 1'b1;
    push_group(2'b10, 1'b1, 64'h8000_0100, 64'h2);
    checks++; if (occupancy !== 5'd2) begin failures++; $display("FAIL t2_occ got=%0d exp=2", occupancy); end
    checks++; if (bus.chk_kind !== 1'b0 || bus.chk_pc !== 64'h8000_0104) begin failures++; $display("FAIL t2_lane1 got=%b/%h exp=0/80000104", bus.chk_kind, bus.chk_pc); end
    @(negedge clock);
    checks++; if (bus.chk_kind !== 1'b1 || bus.chk_cause !== 64'h2) begin failures++; $display("FAIL t2_trap got=%b/%h exp=1/2", bus.chk_kind, bus.chk_cause); end
    @(negedge clock);
    checks++; if (bus.chk_valid !== 1'b0) begin failures++; $display("FAIL t2_empty got=%b exp=0", bus.chk_valid); end
  endtask

  task automatic test_overflow();
    bus.chk_ready = 1'b0;
    exp_q.delete();
    for (int g = 0; g < 6; g++) begin
      push_group(2'b11, 1'b1, 64'h1000 + 64'(g * 'h100), 64'(g + 1));
      if (g < 5) begin
        exp_q.push_back({1'b0, 64'h1000 + 64'(g * 'h100)});
        exp_q.push_back({1'b0, 64'h1004 + 64'(g * 'h100)});
        exp_q.push_back({1'b1, 64'(g + 1)});
      end
      if (g == 4) begin
        checks++; if (occupancy !== 5'd15 || overflow !== 1'b0) begin failures++; $display("FAIL t3_pre got=%0d/%b exp=15/0", occupancy, overflow); end
      end
    end
    checks++; if (occupancy !== 5'd15) begin failures++; $display("FAIL t3_occ got=%0d exp=15", occupancy); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL t3_ovf got=%b exp=1", overflow); end
    bus.chk_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      exp_v = exp_q.pop_front();
      got_v = {bus.chk_kind, bus.chk_kind ? bus.chk_cause : bus.chk_pc};
      checks++; if (bus.chk_valid !== 1'b1 || got_v !== exp_v) begin failures++; $display("FAIL t3_drain%0d got=%b/%h exp=1/%h", k, bus.chk_valid, got_v, exp_v); end
      @(negedge clock);
    end
    checks++; if (occupancy !== 5'd0 || bus.chk_valid !== 1'b0 || overflow !== 1'b1) begin failures++; $display("FAIL t3_end got=%0d/%b/%b exp=0/0/1", occupancy, bus.chk_valid, overflow); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    push_group(2'b11, 1'b1, 64'h2000, 64'h5);
    push_group(2'b11, 1'b1, 64'h2100, 64'h6);
    push_group(2'b01, 1'b0, 64'h2200, 64'h0);
    bus.finish_req = 1'b1;
    @(negedge clock);
    bus.finish_req = 1'b0;
    checks++; if (state !== DRAIN || occupancy !== 5'd7) begin failures++; $display("FAIL t6_drain got=%0d/%0d exp=%0d/7", state, occupancy, DRAIN); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (occupancy !== 5'd0 || bus.chk_valid !== 1'b0) begin failures++; $display("FAIL t6_rst got=%0d/%b exp=0/0", occupancy, bus.chk_valid); end
    checks++; if (state !== RUN) begin failures++; $display("FAIL t6_state got=%0d exp=%0d", state, RUN); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_drain_done();
    do_reset();
    push_group(2'b11, 1'b1, 64'h3000, 64'h7);
    push_group(2'b11, 1'b0, 64'h3100, 64'h0);
    checks++; if (occupancy !== 5'd5) begin failures++; $display("FAIL t4_occ5 got=%0d exp=5", occupancy); end
    bus.finish_req = 1'b1;
    bus.chk_ready  = 1'b1;
    @(negedge clock);
    bus.finish_req = 1'b0;
    checks++; if (state !== DRAIN || occupancy !== 5'd4) begin failures++; $display("FAIL t4_drain got=%0d/%0d exp=%0d/4", state, occupancy, DRAIN); end
    for (int k = 3; k >= 1; k--) begin
      @(negedge clock);
      checks++; if (occupancy !== 5'(k) || done !== 1'b0) begin failures++; $display("FAIL t4_step%0d got=%0d/%b exp=%0d/0", k, occupancy, done, k); end
    end
    @(negedge clock);
    checks++; if (done !== 1'b1 || state !== DONE) begin failures++; $display("FAIL t4_done got=%b/%0d exp=1/%0d", done, state, DONE); end
    checks++; if (occupancy !== 5'd0 || bus.chk_valid !== 1'b0) begin failures++; $display("FAIL t4_idle got=%0d/%b exp=0/0", occupancy, bus.chk_valid); end
    push_group(2'b11, 1'b1, 64'h3200, 64'h9);
    checks++; if (occupancy !== 5'd0 || bus.chk_valid !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL t4_frozen got=%0d/%b/%b exp=0/0/1", occupancy, bus.chk_valid, done); end
  endtask

  task automatic test_fail();
    do_reset();
    push_group(2'b11, 1'b1, 64'h4000, 64'h3);
    push_group(2'b01, 1'b0, 64'h4100, 64'h0);
    bus.chk_ready = 1'b1;
    @(negedge clock);
    checks++; if (state !== RUN || occupancy !== 5'd3) begin failures++; $display("FAIL t5_pop1 got=%0d/%0d exp=%0d/3", state, occupancy, RUN); end
    bus.chk_fail   = 1'b1;
    bus.finish_req = 1'b1;
    @(negedge clock);
    bus.chk_fail   = 1'b0;
    bus.finish_req = 1'b0;
    checks++; if (state !== FAIL || {fail, done} !== 2'b10) begin failures++; $display("FAIL t5_fail got=%0d/%b exp=%0d/10", state, {fail, done}, FAIL); end
    checks++; if (occupancy !== 5'd2 || bus.chk_valid !== 1'b0) begin failures++; $display("FAIL t5_hold got=%0d/%b exp=2/0", occupancy, bus.chk_valid); end
    repeat (3) @(negedge clock);
    checks++; if (occupancy !== 5'd2 || bus.chk_valid !== 1'b0 || fail !== 1'b1) begin failures++; $display("FAIL t5_later got=%0d/%b/%b exp=2/0/1", occupancy, bus.chk_valid, fail); end
  endtask

  initial begin
    reset = 1'b1;
    bus.chk_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_two_lanes();
    test_compact_trap();
    test_overflow();
    test_reset_mid_drain();
    test_drain_done();
    test_fail();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
